mem_arbiter: RTL and testbench

Shares the single external memory port between the beta instruction-fetch path and the data load/store path. Each requester holds a request until it receives a one-cycle done pulse. The arbiter serializes accesses through a small FSM, applies round-robin priority on contention, and drives a stall that freezes the PC and register writeback while an access is outstanding. It sits between the beta core/cache and the memory model, in place of direct wiring of `ia`/`memAddr` to memory.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one external memory port between instruction fetch and data access.
// Ports: clk, reset (async active-low), fetch req/addr/rdata/done,
//   data rd/wr/addr/wdata/rdata/done, mem req/we/addr/wdata/rdata/ready,
//   stall, bus_err. Optional MEM_ARB_TIMEOUT_EN adds a ready timeout.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall,
  output logic          bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC,
    DONE
  } state_t;

  state_t state;
  logic   last_gnt;
  logic   gnt_d;
  logic   d_req;
  logic   pick_d;

  assign d_req  = d_rd | d_wr;
  // last_gnt: 0 = fetch, 1 = data; on a tie the other side wins
  assign pick_d = d_req & (~if_req | ~last_gnt);
  assign stall  = (if_req | d_req) & ~(if_done | d_done);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF);

  logic [3:0] cnt;
  logic       err_q;

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      gnt_d     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          if (pick_d) begin
            state     <= DACC;
            gnt_d     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            state    <= IACC;
            gnt_d    <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        IACC, DACC: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == IACC) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we) d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err_q   <= 1'b1;
            if (state == IACC) begin
              if_rdata <= ERR_DATA;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we) d_rdata <= ERR_DATA;
              d_done <= 1'b1;
            end
          end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
          end
`endif
        end
        DONE: begin
          last_gnt <= gnt_d;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        bus_err;

  int checks;
  int errors;
  int stall_cnt;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_rd = 1'b0;
    d_wr = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // reset state
    #3;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // fetch only, minimum latency
    if_req = 1'b1;
    if_addr = 32'h100;
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    #1;
    chk1("f_c0_stall", stall, 1'b1);
    chk1("f_c0_mem_req", mem_req, 1'b0);
    step();
    chk1("f_c1_mem_req", mem_req, 1'b1);
    chk("f_c1_mem_addr", mem_addr, 32'h100);
    chk1("f_c1_mem_we", mem_we, 1'b0);
    chk1("f_c1_stall", stall, 1'b1);
    step();
    chk1("f_c2_if_done", if_done, 1'b1);
    chk("f_c2_if_rdata", if_rdata, 32'h12345678);
    chk1("f_c2_stall", stall, 1'b0);
    chk1("f_c2_mem_req", mem_req, 1'b0);
    chk1("f_c2_d_done", d_done, 1'b0);
    if_req = 1'b0;
    mem_ready = 1'b0;
    step();
    chk1("f_c3_if_done", if_done, 1'b0);

    // contention straight out of reset: data, fetch, data
    #1;
    reset = 1'b0;
    #1;
    chk("c_rst_if_rdata", if_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    if_req = 1'b1;
    if_addr = 32'h104;
    d_rd = 1'b1;
    d_addr = 32'h300;
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA0001;
    step();
    chk("c1_mem_addr", mem_addr, 32'h300);
    chk1("c1_mem_we", mem_we, 1'b0);
    step();
    chk1("c1_d_done", d_done, 1'b1);
    chk1("c1_if_done", if_done, 1'b0);
    chk("c1_d_rdata", d_rdata, 32'hAAAA0001);
    mem_rdata = 32'hBBBB0002;
    step();
    chk1("c_idle_mem_req", mem_req, 1'b0);
    chk1("c_idle_d_done", d_done, 1'b0);
    step();
    chk("c2_mem_addr", mem_addr, 32'h104);
    step();
    chk1("c2_if_done", if_done, 1'b1);
    chk("c2_if_rdata", if_rdata, 32'hBBBB0002);
    chk("c2_d_rdata", d_rdata, 32'hAAAA0001);
    mem_rdata = 32'hCCCC0003;
    step();
    step();
    chk("c3_mem_addr", mem_addr, 32'h300);
    step();
    chk1("c3_d_done", d_done, 1'b1);
    chk("c3_d_rdata", d_rdata, 32'hCCCC0003);
    if_req = 1'b0;
    d_rd = 1'b0;
    mem_ready = 1'b0;
    step();

    // store with 3 wait cycles; inputs change mid-access
    d_wr = 1'b1;
    d_addr = 32'h200;
    d_wdata = 32'hCAFEF00D;
    mem_rdata = 32'h11112222;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk1($sformatf("s%0d_mem_req", k), mem_req, 1'b1);
      chk1($sformatf("s%0d_mem_we", k), mem_we, 1'b1);
      chk($sformatf("s%0d_mem_addr", k), mem_addr, 32'h200);
      chk($sformatf("s%0d_mem_wdata", k), mem_wdata, 32'hCAFEF00D);
      chk1($sformatf("s%0d_d_done", k), d_done, 1'b0);
      if (k == 2) begin
        d_addr = 32'h999;
        d_wdata = 32'h0;
      end
      if (k == 4) mem_ready = 1'b1;
      step();
    end
    chk1("s_d_done", d_done, 1'b1);
    chk("s_d_rdata", d_rdata, 32'hCCCC0003);
    chk1("s_mem_req", mem_req, 1'b0);
    d_wr = 1'b0;
    mem_ready = 1'b0;
    step();
    chk1("s_d_done_after", d_done, 1'b0);

    // async reset during a data read
    d_rd = 1'b1;
    d_addr = 32'h400;
    step();
    chk1("r_mem_req", mem_req, 1'b1);
    chk("r_mem_addr", mem_addr, 32'h400);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk1("r_async_mem_req", mem_req, 1'b0);
    chk1("r_async_d_done", d_done, 1'b0);
    chk("r_async_mem_addr", mem_addr, 32'h0);
    chk("r_async_d_rdata", d_rdata, 32'h0);
    d_rd = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step();
    chk1("r_post_d_done", d_done, 1'b0);
    chk1("r_post_mem_req", mem_req, 1'b0);
    mem_ready = 1'b0;
    step();
    chk1("r_idle_mem_req", mem_req, 1'b0);

    // fetch with wait states: stall high for 6 cycles
    if_req = 1'b1;
    if_addr = 32'h500;
    mem_rdata = 32'h55556666;
    stall_cnt = 0;
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (stall) stall_cnt++;
      if (c >= 1 && c <= 5) begin
        chk($sformatf("w%0d_mem_addr", c), mem_addr, 32'h500);
        chk1($sformatf("w%0d_mem_req", c), mem_req, 1'b1);
      end
      if (c == 5) mem_ready = 1'b1;
      if (c == 6) begin
        chk1("w_if_done", if_done, 1'b1);
        chk("w_if_rdata", if_rdata, 32'h55556666);
        chk1("w_bus_err", bus_err, 1'b0);
      end
      if (c < 6) step();
    end
    chk("w_stall_cycles", 32'(stall_cnt), 32'd6);
    if_req = 1'b0;
    mem_ready = 1'b0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // read that never sees mem_ready
    d_rd = 1'b1;
    d_addr = 32'h600;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk1($sformatf("t%0d_mem_req", c), mem_req, 1'b1);
    end
    step();
    chk1("t_mem_req", mem_req, 1'b0);
    chk1("t_d_done", d_done, 1'b1);
    chk1("t_bus_err", bus_err, 1'b1);
    chk("t_d_rdata", d_rdata, 32'hDEADBEEF);
    d_rd = 1'b0;
    step();
    chk1("t_bus_err_after", bus_err, 1'b0);
    chk1("t_d_done_after", d_done, 1'b0);
`else
    // without the timeout the access waits for mem_ready
    d_rd = 1'b1;
    d_addr = 32'h600;
    mem_rdata = 32'h77778888;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 20) mem_ready = 1'b1;
    end
    chk1("n_mem_req", mem_req, 1'b1);
    chk1("n_bus_err", bus_err, 1'b0);
    chk1("n_d_done_wait", d_done, 1'b0);
    step();
    chk1("n_d_done", d_done, 1'b1);
    chk("n_d_rdata", d_rdata, 32'h77778888);
    chk1("n_bus_err_done", bus_err, 1'b0);
    d_rd = 1'b0;
    mem_ready = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
